// File: rtl/vr_regfile_mp.sv
// -----------------------------------------------------------------------------
// vr_regfile_mp
// Multi-port register file between decode (read addresses) and writeback
// (two retire lanes). NUM_READ combinational read ports, two write lanes
// (lane 1 has priority), optional hardwired zero register and optional
// same-cycle write-to-read bypass. After reset the array is filled by a
// sequential init sweep; READY rises once every entry has been written.
//
// Ports
//   CLK    clock, rising edge
//   RST    synchronous active-high reset; restarts the init sweep
//   RR     read addresses, port p = RR[p*ADDR_W +: ADDR_W]
//   RD     read data,      port p = RD[p*DATA_W +: DATA_W]
//   WE0/WR0/WD0  write lane 0 (enable, address, data)
//   WE1/WR1/WD1  write lane 1 (enable, address, data), wins on same address
//   READY  1 once the init sweep is complete
//   WCOLL  sticky flag: both lanes wrote the same (non-hardwired) address
// -----------------------------------------------------------------------------
module vr_regfile_mp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_READ  = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_READ*ADDR_W-1:0]   RR,
  output logic [NUM_READ*DATA_W-1:0]   RD,
  input  logic                         WE0,
  input  logic [ADDR_W-1:0]            WR0,
  input  logic [DATA_W-1:0]            WD0,
  input  logic                         WE1,
  input  logic [ADDR_W-1:0]            WR1,
  input  logic [DATA_W-1:0]            WD1,
  output logic                         READY,
  output logic                         WCOLL
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   cnt_nxt;
  logic                wcoll_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr0_is_zero;
  logic                wr1_is_zero;
  logic                we0_eff;
  logic                we1_eff;
  logic                coll;

  // Value loaded into entry idx during the init sweep.
  function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] idx);
    if (INIT_MODE != 0) return DATA_W'(idx);
    return '0;
  endfunction

  assign READY = (state == S_RUN);

  // Writes to the hardwired zero entry are dropped entirely, so they neither
  // update the array, nor bypass, nor count as a collision.
  assign wr0_is_zero = (ZERO_REG != 0) && (WR0 == '0);
  assign wr1_is_zero = (ZERO_REG != 0) && (WR1 == '0);
  assign we0_eff     = WE0 && READY && !wr0_is_zero;
  assign we1_eff     = WE1 && READY && !wr1_is_zero;
  assign coll        = we0_eff && we1_eff && (WR0 == WR1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wcoll_nxt = WCOLL;
    case (state)
      S_INIT: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (&cnt) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (coll) wcoll_nxt = 1'b1;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_INIT;
      cnt   <= '0;
      WCOLL <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      WCOLL <= wcoll_nxt;
    end
  end

  // Storage is not reset; the init sweep fills it. Lane 1 is written after
  // lane 0 so it wins when both target the same entry.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == S_INIT) begin
        mem[cnt] <= init_value(cnt);
      end else begin
        if (we0_eff) mem[WR0] <= WD0;
        if (we1_eff) mem[WR1] <= WD1;
      end
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = RR[p*ADDR_W +: ADDR_W];

    // Priority low to high: array, lane 0 bypass, lane 1 bypass, then the
    // forced-zero cases (init in progress, hardwired zero entry).
    always_comb begin
      rv = mem[ra];
      if ((BYPASS != 0) && we0_eff && (WR0 == ra)) rv = WD0;
      if ((BYPASS != 0) && we1_eff && (WR1 == ra)) rv = WD1;
      if (!READY || ((ZERO_REG != 0) && (ra == '0))) rv = '0;
    end

    assign RD[p*DATA_W +: DATA_W] = rv;
  end

endmodule
